// File: rtl/mdclcg_step_ctrl.sv
// rtl/mdclcg_step_ctrl.sv - one MDCLCG step x' = (a*x + c) mod m via MSB-first interleaved modmul
// Optional feature: MDCLCG_AUTO_RUN_EN (back-to-back steps while run is high).

module comparator_adder (
  input  logic [64:0] a_in,
  input  logic [64:0] b_in,
  output logic [64:0] sum,
  output logic        carry
);
  assign {carry, sum} = {1'b0, a_in} + {1'b0, b_in};
endmodule

module mdclcg_step_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] a_mult,
  input  logic [WIDTH-1:0] c_inc,
  input  logic [WIDTH-1:0] mod_m,
  input  logic             run,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PAD = 65 - WIDTH;

  typedef enum logic [2:0] {IDLE, DBL, ADD, INC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_out_q, x_out_d;
  logic [64:0]      mneg_q, mneg_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [64:0]      t;
  logic [64:0]      cmp_sum;
  logic             cmp_carry;
  logic [64:0]      red;
  logic [WIDTH-1:0] red_w;
  logic             unused_red_hi;

  // Single shared comparator: carry-out set exactly when t >= m.
  comparator_adder u_cmp (
    .a_in  (t),
    .b_in  (mneg_q),
    .sum   (cmp_sum),
    .carry (cmp_carry)
  );

  always_comb begin
    t = '0;
    case (state_q)
      DBL:     t = {{PAD{1'b0}}, acc_q} << 1;
      ADD:     t = {{PAD{1'b0}}, acc_q} + (a_q[idx_q] ? {{PAD{1'b0}}, x_q} : 65'd0);
      INC:     t = {{PAD{1'b0}}, acc_q} + {{PAD{1'b0}}, c_q};
      default: t = '0;
    endcase
  end

  assign red           = cmp_carry ? cmp_sum : t;
  assign red_w         = red[WIDTH-1:0];
  assign unused_red_hi = &{1'b0, red[64:WIDTH]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    c_d     = c_q;
    x_d     = x_q;
    acc_d   = acc_q;
    x_out_d = x_out_q;
    mneg_d  = mneg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          x_out_d = seed;
        end else if (start) begin
          a_d     = a_mult;
          c_d     = c_inc;
          x_d     = x_out_q;
          mneg_d  = ~{{PAD{1'b0}}, mod_m} + 65'd1;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = DBL;
        end
      end
      DBL: begin
        acc_d   = red_w;
        state_d = ADD;
      end
      ADD: begin
        acc_d = red_w;
        if (idx_q == '0) begin
          state_d = INC;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = DBL;
        end
      end
      INC: begin
        // x_out is written here so it already shows the new value while done is high.
        acc_d   = red_w;
        x_out_d = red_w;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
`ifdef MDCLCG_AUTO_RUN_EN
        // Doubling acc=0 yields 0, so DONE stands in for the first DBL and the next state is ADD.
        if (run) begin
          a_d     = a_mult;
          c_d     = c_inc;
          x_d     = acc_q;
          mneg_d  = ~{{PAD{1'b0}}, mod_m} + 65'd1;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = ADD;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef MDCLCG_AUTO_RUN_EN
  logic unused_run;
  assign unused_run = run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      c_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      x_out_q <= '0;
      mneg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      x_out_q <= x_out_d;
      mneg_q  <= mneg_d;
      idx_q   <= idx_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign x_out = x_out_q;

endmodule

// File: tb/tb_mdclcg_step_ctrl.sv
// tb/tb_mdclcg_step_ctrl.sv - directed self-checking bench for mdclcg_step_ctrl
// Optional auto-run scenario is compiled only with MDCLCG_AUTO_RUN_EN.

module tb_mdclcg_step_ctrl;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         seed_load;
  logic [W-1:0] seed;
  logic [W-1:0] a_mult;
  logic [W-1:0] c_inc;
  logic [W-1:0] mod_m;
  logic         run;
  logic         busy;
  logic         done;
  logic [W-1:0] x_out;

  int tests_run = 0;
  int tests_failed = 0;

  mdclcg_step_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .a_mult    (a_mult),
    .c_inc     (c_inc),
    .mod_m     (mod_m),
    .run       (run),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [W-1:0] s);
    seed      = s;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] c, input logic [W-1:0] m);
    a_mult = a;
    c_inc  = c;
    mod_m  = m;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Current cycle counts as 1; returns the cycle number in which done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++;
    if (x_out !== '0) begin tests_failed++; $display("FAIL reset_x got %0d want 0", x_out); end
    do_seed(64'd9);
    tests_run++;
    if (x_out !== 64'd9) begin tests_failed++; $display("FAIL seed9 got %0d want 9", x_out); end
    do_start(64'd5, 64'd3, 64'd13);
    repeat (39) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || x_out !== '0) begin
      tests_failed++;
      $display("FAIL midreset got busy=%b done=%b x=%0d want 0 0 0", busy, done, x_out);
    end
    step();
    rst_n = 1'b1;
    step();
    do_start(64'd5, 64'd3, 64'd13);
    wait_done(cyc);
    tests_run++;
    if (cyc !== 130) begin tests_failed++; $display("FAIL after_reset_latency got %0d want 130", cyc); end
    tests_run++;
    if (x_out !== 64'd3) begin tests_failed++; $display("FAIL after_reset_x got %0d want 3", x_out); end
    step();
  endtask

  task automatic test_minstd();
    int cyc;
    do_seed(64'd1);
    do_start(64'd16807, 64'd0, 64'h7FFF_FFFF);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_cycle1 got %b want 1", busy); end
    wait_done(cyc);
    tests_run++;
    if (cyc !== 130) begin tests_failed++; $display("FAIL minstd_latency got %0d want 130", cyc); end
    tests_run++;
    if (x_out !== 64'd16807) begin tests_failed++; $display("FAIL minstd1 got %0d want 16807", x_out); end
    step();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_done got busy=%b done=%b want 0 0", busy, done);
    end
    do_start(64'd16807, 64'd0, 64'h7FFF_FFFF);
    wait_done(cyc);
    tests_run++;
    if (x_out !== 64'd282475249) begin tests_failed++; $display("FAIL minstd2 got %0d want 282475249", x_out); end
    step();
  endtask

  task automatic test_small_priority();
    int cyc;
    int dones;
    int busies;
    do_seed(64'd7);
    do_start(64'd5, 64'd3, 64'd13);
    wait_done(cyc);
    tests_run++;
    if (x_out !== 64'd12) begin tests_failed++; $display("FAIL small got %0d want 12", x_out); end
    step();
    seed      = 64'd4;
    seed_load = 1'b1;
    start     = 1'b1;
    step();
    seed_load = 1'b0;
    start     = 1'b0;
    tests_run++;
    if (x_out !== 64'd4) begin tests_failed++; $display("FAIL priority_seed got %0d want 4", x_out); end
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 140; i++) begin
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
      step();
    end
    tests_run++;
    if (dones !== 0 || busies !== 0) begin
      tests_failed++;
      $display("FAIL priority_nostep got dones=%0d busy_cycles=%0d want 0 0", dones, busies);
    end
  endtask

  task automatic test_max_operands();
    int cyc;
    logic [W-1:0] m;
    m = 64'hFFFF_FFFF_FFFF_FFFF;
    do_seed(m - 64'd1);
    do_start(m - 64'd1, m - 64'd1, m);
    wait_done(cyc);
    tests_run++;
    if (cyc !== 130) begin tests_failed++; $display("FAIL max_latency got %0d want 130", cyc); end
    tests_run++;
    if (x_out !== '0) begin tests_failed++; $display("FAIL max got %0h want 0", x_out); end
    step();
  endtask

  task automatic test_ignore_busy();
    int dones;
    int first;
    do_seed(64'd7);
    do_start(64'd5, 64'd3, 64'd13);
    dones = 0;
    first = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = cyc;
      end
      if (cyc == 10 || cyc == 60) begin
        start  = 1'b1;
        a_mult = 64'd11;
        c_inc  = 64'd1;
        mod_m  = 64'd17;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    tests_run++;
    if (dones !== 1) begin tests_failed++; $display("FAIL ignore_dones got %0d want 1", dones); end
    tests_run++;
    if (first !== 130) begin tests_failed++; $display("FAIL ignore_latency got %0d want 130", first); end
    tests_run++;
    if (x_out !== 64'd12) begin tests_failed++; $display("FAIL ignore_x got %0d want 12", x_out); end
  endtask

`ifdef MDCLCG_AUTO_RUN_EN
  task automatic test_auto_run();
    int cyc;
    do_seed(64'd1);
    run = 1'b1;
    do_start(64'd16807, 64'd0, 64'h7FFF_FFFF);
    wait_done(cyc);
    tests_run++;
    if (cyc !== 130 || x_out !== 64'd16807) begin
      tests_failed++;
      $display("FAIL auto1 got cyc=%0d x=%0d want 130 16807", cyc, x_out);
    end
    step();
    wait_done(cyc);
    tests_run++;
    if (cyc !== 129 || x_out !== 64'd282475249) begin
      tests_failed++;
      $display("FAIL auto2 got cyc=%0d x=%0d want 129 282475249", cyc, x_out);
    end
    run = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL auto_busy got %b want 1", busy); end
    wait_done(cyc);
    tests_run++;
    if (cyc !== 129 || x_out !== 64'd1622650073) begin
      tests_failed++;
      $display("FAIL auto3 got cyc=%0d x=%0d want 129 1622650073", cyc, x_out);
    end
    step();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL auto_stop got %b want 0", busy); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    a_mult    = '0;
    c_inc     = '0;
    mod_m     = '0;
    run       = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_minstd();
    test_small_priority();
    test_max_operands();
    test_ignore_busy();
`ifdef MDCLCG_AUTO_RUN_EN
    test_auto_run();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
